// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared constants for the instruction fetch stage.
//                Provides the fetch FSM state encoding, the instruction
//                word width and the memory timeout length.
//  Revision    : 1.0  initial release
// ============================================================================
package ifetch_pkg;

    localparam int INSTR_W               = 16;
    localparam int IFETCH_TIMEOUT_CYCLES = 15;

    // Fetch FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch stage feeding the instruction decoder. Holds the PC,
//                reads one 16-bit word per slot from instruction memory over
//                a req/ack handshake, presents it with a one-cycle
//                dec_enable pulse, then waits for next_ready (retire) before
//                fetching again. Branch redirects are applied at retire.
//  Optional    : IFETCH_TIMEOUT_EN - when defined, 15 consecutive REQ cycles
//                without mem_ack set the sticky fault flag and park the FSM
//                in IDLE until reset. When undefined, fault is tied to 0.
//  Ports       : clock, reset (sync, active-low), run,
//                mem_req/mem_addr/mem_ack/mem_rdata (memory side),
//                instruct/dec_enable (decoder side), next_ready,
//                branch_take/branch_target, pc, fault
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instruct,
    output logic               dec_enable,
    input  logic               next_ready,
    input  logic               branch_take,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               fault
);

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instruct;
    logic               r_mem_req;
    logic               r_dec_enable;
    logic               w_fault;

`ifdef IFETCH_TIMEOUT_EN
    logic               r_fault;
    logic [3:0]         r_tcount;
    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            // Any ack arriving in the reset cycle is dropped here.
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_instruct   <= '0;
            r_mem_req    <= 1'b0;
            r_dec_enable <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            r_fault      <= 1'b0;
            r_tcount     <= '0;
`endif
        end else begin
            // dec_enable is a single-cycle pulse; only REQ->ISSUE raises it.
            r_dec_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (run && !w_fault) begin
                        r_state   <= REQ;
                        r_mem_req <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
                        r_tcount  <= '0;
`endif
                    end
                end
                REQ: begin
                    // run is deliberately not looked at: an issued request
                    // always completes (or times out).
                    if (mem_ack) begin
                        r_instruct   <= mem_rdata;
                        r_pc         <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_mem_req    <= 1'b0;
                        r_dec_enable <= 1'b1;
                        r_state      <= ISSUE;
`ifdef IFETCH_TIMEOUT_EN
                    end else if (r_tcount == 4'(IFETCH_TIMEOUT_CYCLES - 1)) begin
                        // This is the last allowed REQ cycle without an ack.
                        r_fault      <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_tcount     <= r_tcount + 4'd1;
`endif
                    end
                end
                ISSUE: begin
                    r_state <= HOLD;
                end
                HOLD: begin
                    // Redirects only take effect together with retire.
                    if (next_ready) begin
                        if (branch_take) begin
                            r_pc <= branch_target;
                        end
                        if (run) begin
                            r_state   <= REQ;
                            r_mem_req <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
                            r_tcount  <= '0;
`endif
                        end else begin
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_pc;
    assign pc         = r_pc;
    assign instruct   = r_instruct;
    assign dec_enable = r_dec_enable;
    assign fault      = w_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch. A transaction
//                level model tracks the expected PC and captured word; each
//                fetch slot uses randomized memory latency, hold length,
//                branch redirects and run level. A second instance with
//                RESET_PC = 16'hFFFF exercises PC wrap. The timeout section
//                follows IFETCH_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        run, mem_ack, next_ready, branch_take;
    logic [15:0] mem_rdata, branch_target;
    logic        mem_req, dec_enable, fault;
    logic [15:0] mem_addr, instruct, pc;

    // Wrap instance signals
    logic        run_w, mem_ack_w, next_ready_w;
    logic [15:0] mem_rdata_w;
    logic        mem_req_w, dec_enable_w, fault_w;
    logic [15:0] mem_addr_w, instruct_w, pc_w;

    int errors = 0;
    int checks = 0;

    logic [15:0] mpc;     // expected PC
    logic [15:0] minstr;  // expected captured word

    always #5 clock = ~clock;

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instruct(instruct), .dec_enable(dec_enable),
        .next_ready(next_ready), .branch_take(branch_take),
        .branch_target(branch_target), .pc(pc), .fault(fault)
    );

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_w (
        .clock(clock), .reset(reset), .run(run_w),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w),
        .mem_rdata(mem_rdata_w), .instruct(instruct_w),
        .dec_enable(dec_enable_w), .next_ready(next_ready_w),
        .branch_take(1'b0), .branch_target(16'h0000), .pc(pc_w),
        .fault(fault_w)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One fetch slot. Entry: DUT has just entered REQ with PC = mpc.
    // Exit: DUT is again just entering REQ (idle detour taken if run_next=0).
    task automatic fetch(input int wt, input logic [15:0] data, input int hold,
                         input bit br, input logic [15:0] tgt, input bit run_next);
        check("req", mem_req, 1);
        check("req_addr", mem_addr, mpc);
        check("req_fault", fault, 0);
        for (int i = 0; i < wt; i++) begin
            mem_ack       = 1'b0;
            run           = 1'($urandom);   // ignored in REQ
            next_ready    = 1'($urandom);   // ignored outside HOLD
            branch_take   = 1'($urandom);
            branch_target = 16'($urandom);
            step();
            check("req_wait", mem_req, 1);
            check("req_wait_pc", pc, mpc);
            check("req_wait_den", dec_enable, 0);
        end
        mem_ack     = 1'b1;
        mem_rdata   = data;
        next_ready  = 1'($urandom);
        branch_take = 1'($urandom);
        step();
        mpc    = mpc + 16'd1;
        minstr = data;
        check("issue_den", dec_enable, 1);
        check("issue_instr", instruct, minstr);
        check("issue_pc", pc, mpc);
        check("issue_req", mem_req, 0);
        mem_ack     = 1'b0;
        mem_rdata   = 16'($urandom);
        next_ready  = 1'($urandom);    // still ISSUE: ignored
        branch_take = 1'($urandom);
        step();
        check("hold_den", dec_enable, 0);
        check("hold_instr", instruct, minstr);
        check("hold_pc", pc, mpc);
        for (int i = 0; i < hold; i++) begin
            next_ready    = 1'b0;
            branch_take   = 1'($urandom);
            branch_target = 16'($urandom);
            mem_ack       = 1'($urandom);  // spurious ack, must be ignored
            mem_rdata     = 16'($urandom);
            run           = 1'($urandom);
            step();
            check("hold_wait_pc", pc, mpc);
            check("hold_wait_instr", instruct, minstr);
            check("hold_wait_req", mem_req, 0);
            check("hold_wait_den", dec_enable, 0);
        end
        mem_ack       = 1'b0;
        next_ready    = 1'b1;
        branch_take   = br;
        branch_target = tgt;
        run           = run_next;
        step();
        next_ready  = 1'b0;
        branch_take = 1'b0;
        if (br) mpc = tgt;
        check("retire_pc", pc, mpc);
        check("retire_req", mem_req, 32'(run_next));
        if (!run_next) begin
            run = 1'b0;
            for (int i = 0; i < 3; i++) begin
                mem_ack = 1'($urandom);
                step();
                check("idle_req", mem_req, 0);
                check("idle_instr", instruct, minstr);
            end
            mem_ack = 1'b0;
            run     = 1'b1;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; run = 1'b0; mem_ack = 1'b0; next_ready = 1'b0;
        branch_take = 1'b0; mem_rdata = '0; branch_target = '0;
        run_w = 1'b0; mem_ack_w = 1'b0; next_ready_w = 1'b0; mem_rdata_w = '0;
        mpc = 16'h0000; minstr = 16'h0000;

        // Reset held low for two cycles
        step(); step();
        check("rst_req", mem_req, 0);
        check("rst_den", dec_enable, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_instr", instruct, 16'h0000);
        check("rst_fault", fault, 0);
        check("rst_pc_w", pc_w, 16'hFFFF);

        reset = 1'b1;
        step();
        check("idle_norun_req", mem_req, 0);
        run = 1'b1;
        step();

        // First fetch with immediate ack, then delayed ack and sequential fetches
        fetch(0, 16'h1234, 0, 1'b0, 16'h0000, 1'b1);
        fetch(4, 16'hA001, 1, 1'b0, 16'h0000, 1'b1);
        fetch(4, 16'hA002, 2, 1'b0, 16'h0000, 1'b1);
        // Branch redirect at retire, preceded by ignored branch_take in HOLD
        fetch(1, 16'hB000, 3, 1'b1, 16'h0040, 1'b1);
        check("branch_addr", mem_addr, 16'h0040);
        // Run low at retire -> IDLE
        fetch(2, 16'hC000, 1, 1'b0, 16'h0000, 1'b0);

        // Randomized slots
        for (int n = 0; n < 30; n++) begin
            fetch(int'($urandom_range(0, 6)), 16'($urandom),
                  int'($urandom_range(0, 4)), 1'($urandom),
                  16'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Reset while in REQ with an ack pending: ack discarded
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        reset     = 1'b0;
        step();
        check("abort_req", mem_req, 0);
        check("abort_pc", pc, 16'h0000);
        check("abort_instr", instruct, 16'h0000);
        check("abort_den", dec_enable, 0);
        mem_ack = 1'b0;
        reset   = 1'b1;
        run     = 1'b1;
        mpc     = 16'h0000;
        minstr  = 16'h0000;
        step();
        check("after_abort_req", mem_req, 1);
        check("after_abort_addr", mem_addr, 16'h0000);

        // Memory never acks
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            step();
            check("to_wait_req", mem_req, 1);
            check("to_wait_fault", fault, 0);
        end
        step();
        check("to_fault", fault, 1);
        check("to_req", mem_req, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("to_parked_req", mem_req, 0);
            check("to_sticky", fault, 1);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            check("nt_wait_req", mem_req, 1);
            check("nt_fault", fault, 0);
        end
`endif
        run   = 1'b0;
        reset = 1'b0;
        step();
        check("clr_fault", fault, 0);
        check("clr_req", mem_req, 0);
        reset = 1'b1;
        step();

        // PC wrap on the RESET_PC = FFFF instance
        check("w_pc_rst", pc_w, 16'hFFFF);
        run_w = 1'b1;
        step();
        check("w_req", mem_req_w, 1);
        check("w_addr", mem_addr_w, 16'hFFFF);
        mem_ack_w   = 1'b1;
        mem_rdata_w = 16'h5A5A;
        step();
        mem_ack_w = 1'b0;
        check("w_pc_wrap", pc_w, 16'h0000);
        check("w_den", dec_enable_w, 1);
        check("w_instr", instruct_w, 16'h5A5A);
        step();
        next_ready_w = 1'b1;
        step();
        next_ready_w = 1'b0;
        check("w_req2", mem_req_w, 1);
        check("w_addr2", mem_addr_w, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
